qpu_trigger_unit: RTL and testbench

Timed event issuer on the receiving end of the EXU trigger interface. It owns the QPU time counter and returns it to the EXU as `trigger_i_clk`. It accepts timestamped event words per event slot, buffers each slot in a small FIFO, and issues each codeword to the waveform/measurement back-end when the counter reaches the event's timestamp. It sits between QPU_exu and the analog front-end drivers.

---
 rtl/qpu_trigger_unit_pkg.sv | 21 ++
 rtl/qpu_trigger_unit_if.sv | 34 +++
 rtl/qpu_trigger_unit_fifo.sv | 46 ++++
 rtl/qpu_trigger_unit.sv | 127 ++++++++++++
 tb/tb_qpu_trigger_unit.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qpu_trigger_unit_pkg.sv
// Shared types and defaults for the QPU trigger unit.
// Event word layout: {timestamp, codeword}, codeword in the low bits.
package qpu_trigger_unit_pkg;

  localparam int DEF_EVENT_NUM  = 4;
  localparam int DEF_TIME_W     = 16;
  localparam int DEF_CW_W       = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  localparam int CW_LSB = 0;

  typedef enum logic {
    ST_WAIT  = 1'b0,
    ST_ISSUE = 1'b1
  } trig_state_e;

  function automatic int ts_lsb(int cw_w);
    return CW_LSB + cw_w;
  endfunction

endpackage

// File: rtl/qpu_trigger_unit_if.sv
// EXU-side / AWG-side / status bundle of the QPU trigger unit.
// slave = trigger unit, master = EXU/back-end side.
interface qpu_trigger_unit_if #(
  parameter int EVENT_NUM = 4,
  parameter int TIME_W    = 16,
  parameter int CW_W      = 8
);
  logic                                 exu_i_clk_ena;
  logic [TIME_W-1:0]                    exu_o_clk;
  logic [EVENT_NUM-1:0]                 exu_i_valid;
  logic [EVENT_NUM*(TIME_W+CW_W)-1:0]   exu_i_data;
  logic [EVENT_NUM-1:0]                 awg_o_valid;
  logic [EVENT_NUM*CW_W-1:0]            awg_o_data;
  logic                                 stat_i_clr;
  logic [EVENT_NUM-1:0]                 stat_o_ovf;
  logic [EVENT_NUM-1:0]                 stat_o_late;
  logic                                 busy_o;

  modport slave (
    input  exu_i_clk_ena, exu_i_valid,
    input  exu_i_data, stat_i_clr,
    output exu_o_clk, awg_o_valid,
    output awg_o_data, stat_o_ovf,
    output stat_o_late, busy_o
  );

  modport master (
    output exu_i_clk_ena, exu_i_valid,
    output exu_i_data, stat_i_clr,
    input  exu_o_clk, awg_o_valid,
    input  awg_o_data, stat_o_ovf,
    input  stat_o_late, busy_o
  );
endinterface

// File: rtl/qpu_trigger_unit_fifo.sv
// Per-slot synchronous event FIFO, pointers one bit wider than
// the address so full/empty are distinguishable.
module qpu_trigger_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic         nxt_ne,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_d = wr_q + {{AW{1'b0}}, push};
    rd_d = rd_q + {{AW{1'b0}}, pop};
  end

  assign empty  = (wr_q == rd_q);
  assign full   = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign nxt_ne = (wr_d != rd_d);
  assign head   = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push) mem_q[wr_q[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/qpu_trigger_unit.sv
// Timed event issuer: owns the QPU time counter, issues codewords on match.
// Define QPU_TRIGGER_LATE_CHECK_EN to issue late heads at once and flag them.
module qpu_trigger_unit
  import qpu_trigger_unit_pkg::*;
#(
  parameter int EVENT_NUM  = DEF_EVENT_NUM,
  parameter int TIME_W     = DEF_TIME_W,
  parameter int CW_W       = DEF_CW_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  qpu_trigger_unit_if.slave bus
);
  localparam int EW = TIME_W + CW_W;
  localparam int TS_LSB = ts_lsb(CW_W);

  logic [TIME_W-1:0]            cnt_q, cnt_d;
  logic [EVENT_NUM-1:0]         pop, full, empty, nxt_ne;
  logic [EVENT_NUM-1:0]         ovf_set, ovf_q, ovf_d;
  logic [EVENT_NUM-1:0]         vld;
  logic [EVENT_NUM-1:0][EW-1:0] head;
  logic [EVENT_NUM*CW_W-1:0]    cw_vec;
  logic                         busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q + {{(TIME_W-1){1'b0}}, bus.exu_i_clk_ena};
    ovf_d  = (bus.stat_i_clr ? '0 : ovf_q) | ovf_set;
    busy_d = |nxt_ne;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ovf_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
    end
  end

`ifdef QPU_TRIGGER_LATE_CHECK_EN
  logic [EVENT_NUM-1:0] late_set, late_q, late_d;

  always_comb begin
    late_d = (bus.stat_i_clr ? '0 : late_q) | late_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) late_q <= '0;
    else        late_q <= late_d;
  end

  assign bus.stat_o_late = late_q;
`else
  assign bus.stat_o_late = '0;
`endif

  for (genvar k = 0; k < EVENT_NUM; k++) begin : g_slot
    logic [TIME_W-1:0] dt;
    logic              push, is_late, hit;
    trig_state_e       st_q, st_d;
    logic [CW_W-1:0]   cw_q, cw_d;

    // a full FIFO still takes a word when its head leaves this cycle
    assign push = bus.exu_i_valid[k] && (!full[k] || hit);

    qpu_trigger_fifo #(
      .W     (EW),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (push),
      .pop    (pop[k]),
      .din    (bus.exu_i_data[k*EW +: EW]),
      .full   (full[k]),
      .empty  (empty[k]),
      .nxt_ne (nxt_ne[k]),
      .head   (head[k])
    );

    assign dt = head[k][TS_LSB +: TIME_W] - cnt_q;

`ifdef QPU_TRIGGER_LATE_CHECK_EN
    assign is_late     = dt[TIME_W-1];
    assign late_set[k] = hit && is_late;
`else
    assign is_late = 1'b0;
`endif

    assign hit        = !empty[k] && ((dt == '0) || is_late);
    assign pop[k]     = hit;
    assign ovf_set[k] = bus.exu_i_valid[k] && full[k] && !hit;

    always_comb begin
      st_d = ST_WAIT;
      cw_d = cw_q;
      if (hit) begin
        st_d = ST_ISSUE;
        cw_d = head[k][CW_LSB +: CW_W];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q <= ST_WAIT;
        cw_q <= '0;
      end else begin
        st_q <= st_d;
        cw_q <= cw_d;
      end
    end

    assign vld[k] = (st_q == ST_ISSUE);
    assign cw_vec[k*CW_W +: CW_W] = cw_q;
  end

  assign bus.exu_o_clk   = cnt_q;
  assign bus.awg_o_valid = vld;
  assign bus.awg_o_data  = cw_vec;
  assign bus.stat_o_ovf  = ovf_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_qpu_trigger_unit.sv
// Scoreboard bench for qpu_trigger_unit against a queue-level model.
// Directed test-plan scenarios followed by a randomized phase.
module tb_qpu_trigger_unit;
  localparam int EN = 4;
  localparam int TW = 8;
  localparam int CW = 8;
  localparam int DEPTH = 4;
  localparam int EW = TW + CW;
  localparam int MOD = 1 << TW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  qpu_trigger_unit_if #(
    .EVENT_NUM (EN), .TIME_W (TW), .CW_W (CW)
  ) bus ();

  qpu_trigger_unit #(
    .EVENT_NUM (EN), .TIME_W (TW),
    .CW_W (CW), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_no;
    logic [CW-1:0] cw;
  } iss_t;

  typedef struct {
    int unsigned edge_no;
    logic [TW-1:0] t;
    logic [EN-1:0] ovf;
    logic [EN-1:0] late;
    logic busy;
  } st_t;

  typedef struct {
    int ts;
    int cw;
  } ev_t;

  iss_t sbq[EN][$];
  st_t  stq[$];
  ev_t  mq[EN][$];

  int compared = 0;
  int mismatched = 0;
  int unsigned mon_edge = 0;

  int mcnt = 0;
  logic [EN-1:0] movf = '0;
  logic [EN-1:0] mlate = '0;

  logic          d_rstn = 1'b0;
  logic          d_ena = 1'b0;
  logic          d_clr = 1'b0;
  logic [EN-1:0] d_valid = '0;
  logic [TW-1:0] d_ts [EN];
  logic [CW-1:0] d_cw [EN];

  always @(posedge clk) mon_edge <= mon_edge + 1;

  // monitor: pops expectations whenever the DUT presents output
  task automatic check();
    iss_t e;
    st_t  s;
    for (int k = 0; k < EN; k++) begin
      if (bus.awg_o_valid[k]) begin
        compared++;
        if (sbq[k].size() == 0) begin
          mismatched++;
          $display("FAIL issue_spurious slot%0d edge %0d: got cw %h, required no issue",
                   k, mon_edge, bus.awg_o_data[k*CW +: CW]);
        end else begin
          e = sbq[k].pop_front();
          if (e.edge_no != mon_edge ||
              e.cw != bus.awg_o_data[k*CW +: CW]) begin
            mismatched++;
            $display("FAIL issue slot%0d: got cw %h at edge %0d, required cw %h at edge %0d",
                     k, bus.awg_o_data[k*CW +: CW], mon_edge, e.cw, e.edge_no);
          end
        end
      end
      while (sbq[k].size() > 0 && sbq[k][0].edge_no <= mon_edge) begin
        e = sbq[k].pop_front();
        compared++;
        mismatched++;
        $display("FAIL issue_missing slot%0d: got no issue at edge %0d, required cw %h",
                 k, mon_edge, e.cw);
      end
    end
    while (stq.size() > 0 && stq[0].edge_no < mon_edge) begin
      s = stq.pop_front();
      compared++;
      mismatched++;
      $display("FAIL status_stale: edge %0d unchecked at edge %0d", s.edge_no, mon_edge);
    end
    if (stq.size() > 0 && stq[0].edge_no == mon_edge) begin
      s = stq.pop_front();
      compared++;
      if (s.t != bus.exu_o_clk || s.ovf != bus.stat_o_ovf ||
          s.late != bus.stat_o_late || s.busy != bus.busy_o) begin
        mismatched++;
        $display("FAIL status edge %0d: got clk=%0d ovf=%b late=%b busy=%b, required clk=%0d ovf=%b late=%b busy=%b",
                 mon_edge, bus.exu_o_clk, bus.stat_o_ovf, bus.stat_o_late, bus.busy_o,
                 s.t, s.ovf, s.late, s.busy);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check();
    end
  end

  // reference model: one step per clock edge, plain queue semantics
  task automatic model_step(int unsigned ne);
    logic [EN-1:0] novf, nlate;
    logic busy;
    ev_t h;
    int diff;
    bit due;
    if (!d_rstn) begin
      for (int k = 0; k < EN; k++) begin
        mq[k].delete();
        sbq[k].delete();
      end
      mcnt = 0;
      movf = '0;
      mlate = '0;
      stq.push_back('{ne, '0, '0, '0, 1'b0});
      return;
    end
    novf = '0;
    nlate = '0;
    for (int k = 0; k < EN; k++) begin
      if (mq[k].size() > 0) begin
        h = mq[k][0];
        diff = (h.ts - mcnt + MOD) % MOD;
        due = (diff == 0);
`ifdef QPU_TRIGGER_LATE_CHECK_EN
        if (diff >= MOD / 2) begin
          due = 1'b1;
          nlate[k] = 1'b1;
        end
`endif
        if (due) begin
          sbq[k].push_back('{ne, CW'(h.cw)});
          void'(mq[k].pop_front());
        end
      end
      if (d_valid[k]) begin
        if (mq[k].size() < DEPTH) mq[k].push_back('{int'(d_ts[k]), int'(d_cw[k])});
        else novf[k] = 1'b1;
      end
    end
    movf  = (d_clr ? '0 : movf) | novf;
    mlate = (d_clr ? '0 : mlate) | nlate;
    mcnt  = (mcnt + (d_ena ? 1 : 0)) % MOD;
    busy  = 1'b0;
    for (int k = 0; k < EN; k++) if (mq[k].size() > 0) busy = 1'b1;
    stq.push_back('{ne, TW'(mcnt), movf, mlate, busy});
  endtask

  task automatic tick();
    @(negedge clk);
    rst_n = d_rstn;
    bus.exu_i_clk_ena = d_ena;
    bus.stat_i_clr = d_clr;
    bus.exu_i_valid = d_valid;
    for (int k = 0; k < EN; k++) bus.exu_i_data[k*EW +: EW] = {d_ts[k], d_cw[k]};
    model_step(mon_edge + 1);
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic push1(int k, int ts, int cw);
    d_valid = '0;
    d_valid[k] = 1'b1;
    d_ts[k] = TW'(ts);
    d_cw[k] = CW'(cw);
    tick();
    d_valid = '0;
  endtask

  task automatic wait_cnt(int t);
    int n = 0;
    d_ena = 1'b1;
    while (mcnt != t && n < 2 * MOD) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset(int n);
    d_rstn = 1'b0;
    d_valid = '0;
    run(n);
    d_rstn = 1'b1;
  endtask

  function automatic bit model_busy();
    for (int k = 0; k < EN; k++) if (mq[k].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  initial begin
    int n;
    for (int k = 0; k < EN; k++) begin
      d_ts[k] = '0;
      d_cw[k] = '0;
    end
    bus.exu_i_clk_ena = 1'b0;
    bus.exu_i_valid = '0;
    bus.exu_i_data = '0;
    bus.stat_i_clr = 1'b0;

    do_reset(3);

    // basic issue
    wait_cnt(2);
    push1(0, 10, 8'h5A);
    run(12);

    // simultaneous slots
    d_valid = '1;
    for (int k = 0; k < EN; k++) begin
      d_ts[k] = TW'(20 + 0);
      d_cw[k] = CW'(8'h10 + k);
    end
    tick();
    d_valid = '0;
    run(10);

    // overflow with counter held at 0
    do_reset(1);
    d_ena = 1'b0;
    for (int i = 0; i < 5; i++) push1(1, 100, 8'hC0 + i);
    d_clr = 1'b1;
    tick();
    d_clr = 1'b0;
    run(2);
    d_ena = 1'b1;
    run(110);

    // late head
    do_reset(1);
    wait_cnt(50);
    push1(2, 40, 8'h33);
    run(6);

    // wrap
    wait_cnt(250);
    push1(3, 3, 8'h77);
    run(15);

    // reset with events queued
    d_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      d_ts[k] = TW'(mcnt + 40);
      d_cw[k] = CW'(8'hA0 + k);
    end
    tick();
    d_valid = '0;
    run(5);
    do_reset(2);
    run(60);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      d_rstn = ($urandom % 800) != 0;
      d_ena = ($urandom % 4) != 0;
      d_clr = ($urandom % 50) == 0;
      for (int k = 0; k < EN; k++) begin
        d_valid[k] = ($urandom % 6) == 0;
        d_ts[k] = TW'(mcnt + $urandom_range(0, 40));
        d_cw[k] = CW'($urandom);
      end
      tick();
    end

    // drain everything still queued
    d_rstn = 1'b1;
    d_ena = 1'b1;
    d_clr = 1'b0;
    d_valid = '0;
    n = 0;
    while (model_busy() && n < 1500) begin
      tick();
      n++;
    end
    if (model_busy()) begin
      mismatched++;
      $display("FAIL drain_timeout: events still queued after %0d cycles, required none", n);
    end
    run(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
